// File: rtl/reset_requester_pkg.sv
// -----------------------------------------------------------------------------
// reset_requester_pkg
//   Shared definitions for the reset requester block: FSM state encoding and
//   the bit positions of the sticky reset-cause register.
// -----------------------------------------------------------------------------
package reset_requester_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ASSERT  = 2'd1,
    ST_HOLDOFF = 2'd2
  } req_state_t;

  localparam int CAUSE_BTN = 0;
  localparam int CAUSE_SW  = 1;
  localparam int CAUSE_WDT = 2;

  // Counter width able to hold values 0 .. n-1, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/reset_requester_debounce_sync.sv
// -----------------------------------------------------------------------------
// debounce_sync
//   Brings the asynchronous active-low push-button into the clk domain,
//   debounces it and emits a one-cycle event on each accepted press
//   (debounced 1->0). Releases are debounced too but produce no event.
//
// Parameters
//   DEBOUNCE_CYCLES : cycles the synchronized level must differ from the
//                     debounced level before the new level is accepted.
// Ports
//   clk       in  system clock
//   resetn    in  synchronous active-low reset
//   button_n  in  asynchronous push-button, active-low
//   btn_event out one-cycle pulse on an accepted press (registered)
// -----------------------------------------------------------------------------
module debounce_sync
  import reset_requester_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 240000
) (
  input  logic clk,
  input  logic resetn,
  input  logic button_n,
  output logic btn_event
);

  localparam int                DB_W    = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [DB_W-1:0]   DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

  logic            sync1;
  logic            sync2;
  logic            deb_level;
  logic [DB_W-1:0] db_cnt;

  // NOTE: sequential state is only ever written with non-blocking assignments,
  // so every flop samples the pre-edge values of the others regardless of
  // statement order.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      // Released-button level so that leaving reset never looks like a press.
      sync1     <= 1'b1;
      sync2     <= 1'b1;
      deb_level <= 1'b1;
      db_cnt    <= '0;
      btn_event <= 1'b0;
    end else begin
      sync1     <= button_n;
      sync2     <= sync1;
      btn_event <= 1'b0;
      if (sync2 == deb_level) begin
        db_cnt <= '0;
      end else if (db_cnt == DB_LAST) begin
        deb_level <= sync2;
        db_cnt    <= '0;
        // Only the press edge (1 -> 0) is an event.
        btn_event <= deb_level & ~sync2;
      end else begin
        db_cnt <= db_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/reset_requester.sv
// -----------------------------------------------------------------------------
// reset_requester
//   Generates the active-low external reset request for the clock/reset
//   generator. Sources: debounced push-button, software strobe and an optional
//   watchdog. Each accepted request becomes a PULSE_CYCLES-wide low pulse on
//   reset_req_n followed by HOLDOFF_CYCLES during which every source is
//   ignored. A sticky cause register records which source(s) fired; it is
//   cleared only by resetn or cause_clr, so it survives the reset it requested.
//
// Configuration
//   RESET_REQUESTER_WATCHDOG_EN : when defined, the watchdog counter and
//   cause[2] are built. When undefined the watchdog never expires, wdt_enable
//   and wdt_kick are ignored and cause[2] stays 0. Ports are identical.
//
// Ports
//   clk         in  system clock
//   resetn      in  synchronous active-low power-on reset
//   button_n    in  asynchronous push-button, active-low
//   sw_reset    in  one-cycle software reset strobe
//   wdt_enable  in  watchdog counter enable
//   wdt_kick    in  one-cycle watchdog restart strobe
//   cause_clr   in  one-cycle strobe clearing cause
//   reset_req_n out registered reset request, active-low
//   cause[2:0]  out sticky cause: [0] button, [1] software, [2] watchdog
//   busy        out high while in ASSERT or HOLDOFF
// -----------------------------------------------------------------------------
module reset_requester
  import reset_requester_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 240000,
  parameter int PULSE_CYCLES    = 64,
  parameter int HOLDOFF_CYCLES  = 256,
  parameter int WDT_CYCLES      = 24000000
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       button_n,
  input  logic       sw_reset,
  input  logic       wdt_enable,
  input  logic       wdt_kick,
  input  logic       cause_clr,
  output logic       reset_req_n,
  output logic [2:0] cause,
  output logic       busy
);

  localparam int CNT_MAX = (PULSE_CYCLES > HOLDOFF_CYCLES) ? PULSE_CYCLES : HOLDOFF_CYCLES;
  localparam int CNT_W   = cnt_width(CNT_MAX);
  localparam logic [CNT_W-1:0] PULSE_LOAD   = CNT_W'(PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLDOFF_LOAD = CNT_W'(HOLDOFF_CYCLES - 1);

  req_state_t       state;
  logic [CNT_W-1:0] phase_cnt;
  logic             btn_event;
  logic             wdt_expire;
  logic [2:0]       cause_set;
  logic             trig;

  debounce_sync #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_debounce_sync (
    .clk       (clk),
    .resetn    (resetn),
    .button_n  (button_n),
    .btn_event (btn_event)
  );

`ifdef RESET_REQUESTER_WATCHDOG_EN
  localparam int               WDT_W    = cnt_width(WDT_CYCLES);
  localparam logic [WDT_W-1:0] WDT_LAST = WDT_W'(WDT_CYCLES - 1);

  logic [WDT_W-1:0] wdt_cnt;

  // Counts only while enabled and idle; saturates at the terminal count.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      wdt_cnt <= '0;
    end else if (!wdt_enable || wdt_kick || state != ST_IDLE) begin
      wdt_cnt <= '0;
    end else if (wdt_cnt != WDT_LAST) begin
      wdt_cnt <= wdt_cnt + 1'b1;
    end
  end

  // A kick in the terminal cycle wins over expiry.
  assign wdt_expire = wdt_enable && !wdt_kick && (state == ST_IDLE) && (wdt_cnt == WDT_LAST);
`else
  assign wdt_expire = 1'b0;

  logic unused_wdt;
  assign unused_wdt = &{1'b0, wdt_enable, wdt_kick};
`endif

  // Sources are sampled only in IDLE; anything arriving while busy is dropped.
  // NOTE: every variable assigned in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    cause_set = '0;
    if (state == ST_IDLE) begin
      cause_set[CAUSE_BTN] = btn_event;
      cause_set[CAUSE_SW]  = sw_reset;
      cause_set[CAUSE_WDT] = wdt_expire;
    end
  end

  assign trig = |cause_set;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state       <= ST_IDLE;
      phase_cnt   <= '0;
      reset_req_n <= 1'b1;
      busy        <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (trig) begin
            state       <= ST_ASSERT;
            phase_cnt   <= PULSE_LOAD;
            reset_req_n <= 1'b0;
            busy        <= 1'b1;
          end
        end
        ST_ASSERT: begin
          if (phase_cnt == '0) begin
            state       <= ST_HOLDOFF;
            phase_cnt   <= HOLDOFF_LOAD;
            reset_req_n <= 1'b1;
          end else begin
            phase_cnt <= phase_cnt - 1'b1;
          end
        end
        ST_HOLDOFF: begin
          if (phase_cnt == '0) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end else begin
            phase_cnt <= phase_cnt - 1'b1;
          end
        end
        default: begin
          state       <= ST_IDLE;
          phase_cnt   <= '0;
          reset_req_n <= 1'b1;
          busy        <= 1'b0;
        end
      endcase
    end
  end

  // A new set and a clear in the same cycle: the new sources replace the record.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      cause <= '0;
    end else if (trig) begin
      cause <= cause_clr ? cause_set : (cause | cause_set);
    end else if (cause_clr) begin
      cause <= '0;
    end
  end

endmodule

// File: tb/tb_reset_requester.sv
// -----------------------------------------------------------------------------
// tb_reset_requester
//   Self-checking bench for reset_requester with small timing parameters.
//   Expected outputs are scheduled per cycle into a scoreboard queue when the
//   stimulus is driven and compared at the falling edge of the cycle they
//   refer to. Watchdog tests follow RESET_REQUESTER_WATCHDOG_EN.
// -----------------------------------------------------------------------------
module tb_reset_requester;

  localparam int P  = 4;
  localparam int H  = 8;
  localparam int DB = 5;
  localparam int W  = 20;

  localparam int K_RQ    = 0;
  localparam int K_BUSY  = 1;
  localparam int K_CAUSE = 2;

  logic       clk = 1'b0;
  logic       resetn;
  logic       button_n;
  logic       sw_reset;
  logic       wdt_enable;
  logic       wdt_kick;
  logic       cause_clr;
  logic       reset_req_n;
  logic [2:0] cause;
  logic       busy;

  int cyc    = 0;
  int checks = 0;
  int errors = 0;

  typedef struct {
    int    cyc;
    int    kind;
    int    val;
    string tag;
  } exp_t;

  exp_t sb[$];

  reset_requester #(
    .DEBOUNCE_CYCLES (DB),
    .PULSE_CYCLES    (P),
    .HOLDOFF_CYCLES  (H),
    .WDT_CYCLES      (W)
  ) dut (
    .clk         (clk),
    .resetn      (resetn),
    .button_n    (button_n),
    .sw_reset    (sw_reset),
    .wdt_enable  (wdt_enable),
    .wdt_kick    (wdt_kick),
    .cause_clr   (cause_clr),
    .reset_req_n (reset_req_n),
    .cause       (cause),
    .busy        (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic push(input int c, input int kind, input int val, input string tag);
    exp_t e;
    e.cyc  = c;
    e.kind = kind;
    e.val  = val;
    e.tag  = tag;
    sb.push_back(e);
  endtask

  task automatic expect_state(input int c, input int rq, input int bsy, input string tag);
    push(c, K_RQ, rq, {tag, "_req_n"});
    push(c, K_BUSY, bsy, {tag, "_busy"});
  endtask

  task automatic expect_idle(input int a, input int b, input string tag);
    for (int c = a; c <= b; c++) expect_state(c, 1, 0, tag);
  endtask

  // Trigger seen in cycle n: low n+1..n+P, holdoff after, idle again at n+P+H+1.
  task automatic expect_pulse(input int n, input string tag);
    for (int c = n + 1; c <= n + P; c++) expect_state(c, 0, 1, tag);
    for (int c = n + P + 1; c <= n + P + H; c++) expect_state(c, 1, 1, {tag, "_hold"});
    expect_state(n + P + H + 1, 1, 0, {tag, "_end"});
  endtask

  task automatic expect_cause(input int c, input int v, input string tag);
    push(c, K_CAUSE, v, tag);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic goto(input int n);
    while (cyc < n) step();
  endtask

  task automatic clear_cause(input string tag);
    expect_cause(cyc + 1, 0, tag);
    cause_clr = 1'b1;
    step();
    cause_clr = 1'b0;
  endtask

  // Scoreboard consumer: compare every entry scheduled for the current cycle.
  always @(negedge clk) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].cyc == cyc) begin
        case (sb[i].kind)
          K_RQ:    check(sb[i].tag, 32'(reset_req_n), 32'(sb[i].val));
          K_BUSY:  check(sb[i].tag, 32'(busy), 32'(sb[i].val));
          default: check(sb[i].tag, 32'(cause), 32'(sb[i].val));
        endcase
        sb.delete(i);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout at cycle %0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    int d;
    int e;
    int x;
    int ie;

    resetn     = 1'b0;
    button_n   = 1'b1;
    sw_reset   = 1'b0;
    wdt_enable = 1'b0;
    wdt_kick   = 1'b0;
    cause_clr  = 1'b0;

    // Reset values.
    step(); step();
    expect_state(3, 1, 0, "reset");
    expect_cause(3, 0, "reset_cause");
    step();
    resetn = 1'b1;
    expect_idle(4, 10, "post_reset");

    // Software request at cycle 10.
    goto(10);
    n = cyc;
    expect_pulse(n, "sw");
    expect_cause(n + 1, 3'b010, "sw_cause");
    sw_reset = 1'b1;
    step();
    sw_reset = 1'b0;
    goto(n + P + H + 2);
    clear_cause("sw_clr");

    // Bounce (2-cycle phases) then a held press.
    d = cyc + 20;
    expect_idle(cyc, d + 7, "bounce");
    for (int i = 0; i < 10; i++) begin
      button_n = (i % 2 == 1);
      step();
      step();
    end
    button_n = 1'b0;
    n = d + 7;
    expect_pulse(n, "btn");
    expect_cause(n + 1, 3'b001, "btn_cause");
    ie = n + P + H + 1;
    expect_idle(ie + 1, ie + 25, "btn_held_release");
    expect_cause(ie + 25, 3'b001, "btn_release_cause");
    goto(ie + 6);
    button_n = 1'b1;
    goto(ie + 26);
    clear_cause("btn_clr");

`ifdef RESET_REQUESTER_WATCHDOG_EN
    // Expiry W cycles after enabling in IDLE.
    e = cyc;
    wdt_enable = 1'b1;
    expect_idle(e, e + W - 1, "wdt_count");
    expect_pulse(e + W - 1, "wdt");
    expect_cause(e + W, 3'b100, "wdt_cause");
    x = e + W + P + H;
    goto(x);
    // Kicks every 15 cycles, then one kick exactly in the expiry cycle.
    expect_idle(x, x + 240, "wdt_kicked");
    for (int j = 0; j < 14; j++) begin
      wdt_kick = 1'b1;
      step();
      wdt_kick = 1'b0;
      repeat (14) step();
    end
    goto(x + 195 + W);
    wdt_kick = 1'b1;
    step();
    wdt_kick = 1'b0;
    goto(x + 225);
    wdt_enable = 1'b0;
    expect_cause(x + 240, 3'b100, "wdt_kicked_cause");
    goto(x + 241);
    clear_cause("wdt_clr");
`else
    // Watchdog compiled out: enable has no effect.
    e = cyc;
    wdt_enable = 1'b1;
    expect_idle(e, e + 101, "wdt_off");
    expect_cause(e + 101, 0, "wdt_off_cause");
    goto(e + 100);
    wdt_enable = 1'b0;
    goto(e + 102);
`endif

    // Button event and sw_reset in the same cycle, then sw_reset in HOLDOFF.
    d = cyc;
    n = d + 7;
    button_n = 1'b0;
    expect_idle(d, n, "sim_pre");
    expect_pulse(n, "sim");
    expect_cause(n + 1, 3'b011, "sim_cause");
    expect_idle(n + P + H + 1, n + P + H + 12, "drop");
    expect_cause(n + P + H + 2, 3'b011, "drop_cause");
    goto(n);
    sw_reset = 1'b1;
    step();
    sw_reset = 1'b0;
    goto(n + P + 3);
    sw_reset = 1'b1;
    step();
    sw_reset = 1'b0;
    goto(n + P + H + 2);
    button_n = 1'b1;
    goto(n + P + H + 13);

    // cause_clr together with sw_reset: new source replaces the record.
    n = cyc;
    expect_pulse(n, "clr_set");
    expect_cause(n + 1, 3'b010, "clr_vs_set");
    cause_clr = 1'b1;
    sw_reset  = 1'b1;
    step();
    cause_clr = 1'b0;
    sw_reset  = 1'b0;
    goto(n + P + H + 3);

    // resetn asserted in the second ASSERT cycle.
    n = cyc;
    expect_state(n + 1, 0, 1, "mid_a1");
    expect_state(n + 2, 0, 1, "mid_a2");
    expect_cause(n + 2, 3'b010, "mid_cause");
    expect_state(n + 3, 1, 0, "mid_rst");
    expect_cause(n + 3, 0, "mid_rst_cause");
    expect_idle(n + 4, n + 15, "mid_after");
    sw_reset = 1'b1;
    step();
    sw_reset = 1'b0;
    goto(n + 2);
    resetn = 1'b0;
    step();
    resetn = 1'b1;
    goto(n + 17);

    check("sb_drain", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
